// File: rtl/piezo_melody_ctrl_pkg.sv
// Shared constants for the piezo melody controller: note codes, FSM encodings,
// song ROM layout and contents, half-period derivation and the key priority encoder.
package piezo_melody_ctrl_pkg;

    localparam int NOTE_W  = 4;
    localparam int BEATS_W = 4;
    localparam int STEP_W  = 4;
    localparam int DUR_W   = 24;
    localparam int HP_W    = 12;

    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd8;

    localparam logic [STEP_W-1:0] LAST_STEP = 4'd15;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MANUAL = 2'd1;
    localparam logic [1:0] ST_PLAY   = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    typedef struct packed {
        logic [NOTE_W-1:0]  note;
        logic [BEATS_W-1:0] beats;
    } rom_entry_t;

    // Frequencies are held in centi-hertz so the rounding divide stays in integers.
    function automatic logic [HP_W-1:0] half_period(input logic [NOTE_W-1:0] note, input int clk_hz);
        longint fc;
        case (note)
            NOTE_C4: fc = 26163;
            NOTE_D4: fc = 29366;
            NOTE_E4: fc = 32963;
            NOTE_F4: fc = 34923;
            NOTE_G4: fc = 39200;
            NOTE_A4: fc = 44000;
            NOTE_B4: fc = 49388;
            NOTE_C5: fc = 52325;
            default: fc = 0;
        endcase
        if (fc == 0) return '0;
        return HP_W'((longint'(clk_hz) * 100 + fc) / (2 * fc));
    endfunction

    function automatic rom_entry_t song_rom(input logic [STEP_W-1:0] step);
        rom_entry_t e;
        case (step)
            4'd0:    e = '{note: NOTE_C4,   beats: 4'd1};
            4'd1:    e = '{note: NOTE_D4,   beats: 4'd1};
            4'd2:    e = '{note: NOTE_E4,   beats: 4'd1};
            4'd3:    e = '{note: NOTE_F4,   beats: 4'd1};
            4'd4:    e = '{note: NOTE_G4,   beats: 4'd1};
            4'd5:    e = '{note: NOTE_A4,   beats: 4'd1};
            4'd6:    e = '{note: NOTE_B4,   beats: 4'd1};
            4'd7:    e = '{note: NOTE_C5,   beats: 4'd1};
            4'd8:    e = '{note: NOTE_REST, beats: 4'd2};
            default: e = '{note: NOTE_REST, beats: 4'd0};
        endcase
        return e;
    endfunction

    function automatic logic [NOTE_W-1:0] lowest_key(input logic [7:0] keys);
        logic [NOTE_W-1:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (keys[i]) r = NOTE_W'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/piezo_melody_ctrl_tone_gen.sv
// Square-wave generator: toggles the piezo every half period of the selected note
// and restarts cleanly (counter 0, output low) whenever the note changes.
module piezo_tone_gen
    import piezo_melody_ctrl_pkg::*;
#(
    parameter int CLK_HZ = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NOTE_W-1:0] note_idx,
    output logic              piezo
);

    localparam logic [HP_W-1:0] HP_C4 = half_period(NOTE_C4, CLK_HZ);
    localparam logic [HP_W-1:0] HP_D4 = half_period(NOTE_D4, CLK_HZ);
    localparam logic [HP_W-1:0] HP_E4 = half_period(NOTE_E4, CLK_HZ);
    localparam logic [HP_W-1:0] HP_F4 = half_period(NOTE_F4, CLK_HZ);
    localparam logic [HP_W-1:0] HP_G4 = half_period(NOTE_G4, CLK_HZ);
    localparam logic [HP_W-1:0] HP_A4 = half_period(NOTE_A4, CLK_HZ);
    localparam logic [HP_W-1:0] HP_B4 = half_period(NOTE_B4, CLK_HZ);
    localparam logic [HP_W-1:0] HP_C5 = half_period(NOTE_C5, CLK_HZ);

    logic [HP_W-1:0]   r_cnt;
    logic              r_piezo;
    logic [NOTE_W-1:0] r_lastNote;
    logic [HP_W-1:0]   w_hp;
    logic [HP_W-1:0]   w_cnt;
    logic              w_piezoCur;
    logic              w_noteChange;

    always_comb begin
        w_hp = '1;
        case (note_idx)
            NOTE_C4: w_hp = HP_C4;
            NOTE_D4: w_hp = HP_D4;
            NOTE_E4: w_hp = HP_E4;
            NOTE_F4: w_hp = HP_F4;
            NOTE_G4: w_hp = HP_G4;
            NOTE_A4: w_hp = HP_A4;
            NOTE_B4: w_hp = HP_B4;
            NOTE_C5: w_hp = HP_C5;
            default: w_hp = '1;
        endcase
    end

    // The cycle in which the note changes already counts as count 0 with the output low.
    assign w_noteChange = (note_idx != r_lastNote);
    assign w_cnt        = w_noteChange ? '0 : r_cnt;
    assign w_piezoCur   = w_noteChange ? 1'b0 : r_piezo;
    assign piezo        = w_piezoCur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_piezo    <= 1'b0;
            r_lastNote <= '0;
        end else begin
            r_lastNote <= note_idx;
            if (note_idx == NOTE_REST) begin
                r_cnt   <= '0;
                r_piezo <= 1'b0;
            end else if (w_cnt == w_hp - 12'd1) begin
                r_cnt   <= '0;
                r_piezo <= ~w_piezoCur;
            end else begin
                r_cnt   <= w_cnt + 12'd1;
                r_piezo <= w_piezoCur;
            end
        end
    end

endmodule

// File: rtl/piezo_melody_ctrl.sv
// Piezo controller: shares one tone generator between the manual keyboard and the
// ROM melody, the melody taking priority once started.
module piezo_melody_ctrl
    import piezo_melody_ctrl_pkg::*;
#(
    parameter int CLK_HZ      = 1_000_000,
    parameter int BEAT_CYCLES = 250_000,
    parameter int GAP_CYCLES  = 10_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        btn,
    input  logic              play,
    input  logic              stop,
    output logic              piezo,
    output logic              busy,
    output logic [NOTE_W-1:0] note_idx
);

    localparam logic [DUR_W-1:0] BEAT_LEN = DUR_W'(BEAT_CYCLES);
    localparam logic [DUR_W-1:0] GAP_LEN  = DUR_W'(GAP_CYCLES);

    logic [1:0]         r_state;
    logic [STEP_W-1:0]  r_step;
    logic [DUR_W-1:0]   r_durCnt;
    logic [NOTE_W-1:0]  r_noteIdx;
    logic               r_playQ;
    logic               r_playArmed;

    logic               w_playEdge;
    logic               w_startSong;
    logic [BEATS_W-1:0] w_curBeats;
    logic [DUR_W-1:0]   w_noteDur;
    logic [DUR_W-1:0]   w_durInc;
    logic [STEP_W-1:0]  w_stepNext;
    rom_entry_t         w_nextEntry;
    logic [NOTE_W-1:0]  w_firstNote;
    logic [NOTE_W-1:0]  w_btnNote;

    // A play level held through reset must fall once before an edge is accepted.
    assign w_playEdge  = play & ~r_playQ & r_playArmed;
    assign w_startSong = w_playEdge & ~stop;
    assign w_curBeats  = song_rom(r_step).beats;
    assign w_noteDur   = DUR_W'(w_curBeats) * BEAT_LEN;
    assign w_durInc    = (r_durCnt == '1) ? r_durCnt : r_durCnt + 24'd1;
    assign w_stepNext  = r_step + 4'd1;
    assign w_nextEntry = song_rom(w_stepNext);
    assign w_firstNote = song_rom(4'd0).note;
    assign w_btnNote   = lowest_key(btn);

    assign note_idx = r_noteIdx;
    assign busy     = (r_state == ST_PLAY) || (r_state == ST_GAP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_step      <= '0;
            r_durCnt    <= '0;
            r_noteIdx   <= '0;
            r_playQ     <= 1'b0;
            r_playArmed <= 1'b0;
        end else begin
            r_playQ <= play;
            if (!play) r_playArmed <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_startSong) begin
                        r_state   <= ST_PLAY;
                        r_step    <= '0;
                        r_durCnt  <= '0;
                        r_noteIdx <= w_firstNote;
                    end else if (btn != 8'd0) begin
                        r_state   <= ST_MANUAL;
                        r_noteIdx <= w_btnNote;
                    end
                end
                ST_MANUAL: begin
                    if (w_startSong) begin
                        r_state   <= ST_PLAY;
                        r_step    <= '0;
                        r_durCnt  <= '0;
                        r_noteIdx <= w_firstNote;
                    end else if (w_playEdge || btn == 8'd0) begin
                        r_state   <= ST_IDLE;
                        r_noteIdx <= NOTE_REST;
                    end else begin
                        r_noteIdx <= w_btnNote;
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        r_state   <= ST_IDLE;
                        r_noteIdx <= NOTE_REST;
                        r_durCnt  <= '0;
                    end else if (r_durCnt >= w_noteDur - 24'd1) begin
                        r_state   <= ST_GAP;
                        r_noteIdx <= NOTE_REST;
                        r_durCnt  <= '0;
                    end else begin
                        r_durCnt <= w_durInc;
                    end
                end
                ST_GAP: begin
                    if (stop) begin
                        r_state   <= ST_IDLE;
                        r_noteIdx <= NOTE_REST;
                        r_durCnt  <= '0;
                    end else if (r_durCnt >= GAP_LEN - 24'd1) begin
                        r_durCnt <= '0;
                        r_step   <= w_stepNext;
                        if (r_step == LAST_STEP || w_nextEntry.beats == 4'd0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_PLAY;
                            r_noteIdx <= w_nextEntry.note;
                        end
                    end else begin
                        r_durCnt <= w_durInc;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_noteIdx <= NOTE_REST;
                end
            endcase
        end
    end

    piezo_tone_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_toneGen (
        .clk     (clk),
        .rst     (rst),
        .note_idx(r_noteIdx),
        .piezo   (piezo)
    );

endmodule
